// File: rtl/wb_regfile_if.sv
// Write-back / decode bundle between the pipeline and the register file scoreboard.
// The master side (pipeline) drives indices, data and issue; the slave side returns read data and hazards.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              rs_busy;
  logic              rt_busy;
  logic              stall;

  modport master (
    output wb_en, wb_addr, wb_data, rs_addr, rt_addr, issue_en, issue_addr,
    input  rs_data, rt_data, rs_busy, rt_busy, stall
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, rs_addr, rt_addr, issue_en, issue_addr,
    output rs_data, rt_data, rs_busy, rt_busy, stall
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with write-back commit, two combinational read ports
// (optional same-cycle bypass) and a per-register busy scoreboard driving decode stall.
module wb_regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_regfile_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;

  logic wb_write;
  logic issue_take;
  logic rs_fwd;
  logic rt_fwd;

  // Index 0 is hardwired: it is never written and never tracked.
  assign wb_write   = bus.wb_en && (bus.wb_addr != '0);
  assign rs_fwd     = BYPASS && bus.wb_en && (bus.wb_addr == bus.rs_addr) && (bus.rs_addr != '0);
  assign rt_fwd     = BYPASS && bus.wb_en && (bus.wb_addr == bus.rt_addr) && (bus.rt_addr != '0);
  assign issue_take = bus.issue_en && !bus.stall && (bus.issue_addr != '0);

  // Read ports. Data is forced to zero while reset is held so a bypassed
  // write-back cannot leak through during reset.
  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (rst_n) begin
      if (rs_fwd)                   bus.rs_data = bus.wb_data;
      else if (bus.rs_addr != '0)   bus.rs_data = regs[bus.rs_addr];
      if (rt_fwd)                   bus.rt_data = bus.wb_data;
      else if (bus.rt_addr != '0)   bus.rt_data = regs[bus.rt_addr];
    end
  end

  // Hazards: a write-back landing this cycle resolves the hazard only when it is forwarded.
  always_comb begin
    bus.rs_busy = busy[bus.rs_addr] && (bus.rs_addr != '0) && !rs_fwd;
    bus.rt_busy = busy[bus.rt_addr] && (bus.rt_addr != '0) && !rt_fwd;
    bus.stall   = bus.rs_busy || bus.rt_busy;
  end

  // NOTE: combinational next-state uses blocking assignments in order, so the
  // later set intentionally overrides an earlier clear of the same index.
  always_comb begin
    busy_next = busy;
    if (wb_write)   busy_next[bus.wb_addr]    = 1'b0;
    if (issue_take) busy_next[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // NOTE: the register array is built from resettable flops rather than a RAM
  // macro, because every entry must read as zero immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Scoreboard bench: the driver pushes model-predicted outputs, a negedge monitor pops and compares.
module tb_wb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam bit BYPASS = 1'b1;
  localparam int NREG   = 2 ** ADDR_W;

  typedef struct {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_busy;
    logic              rt_busy;
    logic              stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  // Reference state: plain arrays updated from the rules, one call per cycle.
  logic [DATA_W-1:0] m_regs [NREG];
  bit                m_busy [NREG];

  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_read(input bit rst, input bit wbe, input int wba,
                                               input logic [DATA_W-1:0] wbd, input int a);
    if (!rst || a == 0) return '0;
    if (BYPASS && wbe && wba == a) return wbd;
    return m_regs[a];
  endfunction

  function automatic bit m_hazard(input bit rst, input bit wbe, input int wba, input int a);
    if (!rst || a == 0) return 1'b0;
    if (BYPASS && wbe && wba == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply one cycle of inputs, predict outputs, then advance the model across the next edge.
  task automatic drive(input bit rst, input bit wbe, input int wba, input logic [DATA_W-1:0] wbd,
                       input int rsa, input int rta, input bit ise, input int isa);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rst;
    bus.wb_en      = wbe;
    bus.wb_addr    = ADDR_W'(wba);
    bus.wb_data    = wbd;
    bus.rs_addr    = ADDR_W'(rsa);
    bus.rt_addr    = ADDR_W'(rta);
    bus.issue_en   = ise;
    bus.issue_addr = ADDR_W'(isa);
    e.rs_data = m_read(rst, wbe, wba, wbd, rsa);
    e.rt_data = m_read(rst, wbe, wba, wbd, rta);
    e.rs_busy = m_hazard(rst, wbe, wba, rsa);
    e.rt_busy = m_hazard(rst, wbe, wba, rta);
    e.stall   = e.rs_busy | e.rt_busy;
    exp_q.push_back(e);
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wbe && wba != 0) begin
        m_regs[wba] = wbd;
        m_busy[wba] = 1'b0;
      end
      if (ise && !e.stall && isa != 0) m_busy[isa] = 1'b1;
    end
    #2;
  endtask

  task automatic idle(input int rsa, input int rta);
    drive(1, 0, 0, '0, rsa, rta, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_rs_data", bus.rs_data, e.rs_data);
      check("sb_rt_data", bus.rt_data, e.rt_data);
      check("sb_rs_busy", DATA_W'(bus.rs_busy), DATA_W'(e.rs_busy));
      check("sb_rt_busy", DATA_W'(bus.rt_busy), DATA_W'(e.rt_busy));
      check("sb_stall",   DATA_W'(bus.stall),   DATA_W'(e.stall));
    end
  end

  initial begin
    int drain;
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rs_addr = '0; bus.rt_addr = '0; bus.issue_en = 0; bus.issue_addr = '0;
    drive(0, 0, 0, '0, 0, 0, 0, 0);
    check("reset_rs_data", bus.rs_data, '0);
    check("reset_stall", DATA_W'(bus.stall), '0);
    idle(0, 0);

    // 1: reset mid-run clears written data and busy bits; r0 stays zero.
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 1, 12);
    idle(5, 12);
    check("pre_reset_r5", bus.rs_data, 32'hDEADBEEF);
    check("pre_reset_busy12", DATA_W'(bus.rt_busy), 1);
    drive(0, 1, 5, 32'h1111, 5, 12, 0, 0);
    check("in_reset_r5", bus.rs_data, '0);
    check("in_reset_busy", DATA_W'(bus.rt_busy), '0);
    idle(5, 12);
    check("post_reset_r5", bus.rs_data, '0);
    check("post_reset_stall", DATA_W'(bus.stall), '0);
    drive(1, 1, 0, 32'h1234, 0, 0, 0, 0);
    check("r0_wb_bypass", bus.rs_data, '0);
    idle(0, 0);
    check("r0_after_wb", bus.rs_data, '0);

    // 2: write then read with bypass.
    drive(1, 1, 7, 32'hA5A5A5A5, 7, 7, 0, 0);
    check("bypass_rs", bus.rs_data, 32'hA5A5A5A5);
    check("bypass_rt", bus.rt_data, 32'hA5A5A5A5);
    idle(7, 7);
    check("commit_r7", bus.rs_data, 32'hA5A5A5A5);

    // 3: scoreboard stall; issue while stalled is dropped.
    drive(1, 0, 0, '0, 0, 0, 1, 3);
    drive(1, 0, 0, '0, 3, 0, 1, 4);
    check("stall_rs_busy", DATA_W'(bus.rs_busy), 1);
    check("stall_stall", DATA_W'(bus.stall), 1);
    idle(4, 0);
    check("dropped_issue4", DATA_W'(bus.rs_busy), 0);
    drive(1, 1, 3, 32'h55, 3, 0, 0, 0);
    check("wb_resolves_stall", DATA_W'(bus.stall), 0);
    check("wb_bypass_r3", bus.rs_data, 32'h55);

    // 4: simultaneous clear and set of index 9: set wins.
    drive(1, 0, 0, '0, 0, 0, 1, 9);
    drive(1, 1, 9, 32'h99, 0, 0, 1, 9);
    idle(9, 0);
    check("setclr_busy9", DATA_W'(bus.rs_busy), 1);
    check("setclr_r9", bus.rs_data, 32'h99);
    drive(1, 1, 9, 32'h9A, 0, 0, 0, 0);

    // 5: dual-port independence.
    drive(1, 0, 0, '0, 0, 0, 1, 2);
    idle(6, 2);
    check("dual_rs_busy", DATA_W'(bus.rs_busy), 0);
    check("dual_rt_busy", DATA_W'(bus.rt_busy), 1);
    check("dual_stall", DATA_W'(bus.stall), 1);
    drive(1, 1, 2, 32'h22, 6, 2, 0, 0);
    check("dual_rt_cleared", DATA_W'(bus.rt_busy), 0);
    check("dual_stall_cleared", DATA_W'(bus.stall), 0);

    // 6: random regression with occasional reset pulses; small index pool raises collisions.
    for (int n = 0; n < 10000; n++) begin
      bit rst;
      int a [4];
      rst = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < 4; k++)
        a[k] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5) : $urandom_range(0, NREG - 1);
      drive(rst, $urandom_range(0, 2) == 0, a[0], $urandom, a[1], a[2],
            $urandom_range(0, 2) == 0, a[3]);
    end
    idle(0, 0);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
